// File: rtl/alu_rsp_deserializer.sv
// rtl/alu_rsp_deserializer.sv - serial ALU response receiver: frames, response assembly, CRC3/parity checks
// Optional inter-frame timeout enabled by defining ALU_RSP_TIMEOUT_EN.
module alu_rsp_deserializer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        rsp_valid,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic        rsp_crc_ok,
  output logic        rsp_err,
  output logic [5:0]  rsp_err_flags,
  output logic        rsp_par_ok,
  output logic [54:0] rsp_raw,
  output logic        frame_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  data_cnt;
  logic        is_ctl;
  logic [7:0]  pay;
  logic [31:0] c_sr;
  logic [53:0] raw_sr;
  logic        timeout_hit;

  // Serial CRC over {C, 0, flags}, poly x^3+x+1, MSB first, zero init.
  function automatic logic [2:0] crc3(input logic [36:0] bits);
    logic [2:0] crc;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      if (crc[2] ^ bits[i])
        crc = {crc[1:0], 1'b0} ^ 3'b011;
      else
        crc = {crc[1:0], 1'b0};
    end
    return crc;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!sin) state_nxt = S_TYPE;
      S_TYPE:    state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == 3'd0) state_nxt = S_STOP;
      S_STOP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= 3'd7;
      data_cnt      <= 3'd0;
      is_ctl        <= 1'b0;
      pay           <= 8'h00;
      c_sr          <= 32'h0;
      raw_sr        <= 54'h0;
      rsp_valid     <= 1'b0;
      rsp_c         <= 32'h0;
      rsp_flags     <= 4'h0;
      rsp_crc_ok    <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_err_flags <= 6'h0;
      rsp_par_ok    <= 1'b0;
      rsp_raw       <= 55'h0;
      frame_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      frame_err <= 1'b0;
      // Only the last 55 line bits matter: an accepted response is exactly 5 frames.
      if (state != S_IDLE || !sin)
        raw_sr <= {raw_sr[52:0], sin};
      case (state)
        S_IDLE: begin
          if (timeout_hit)
            data_cnt <= 3'd0;
        end
        S_TYPE: begin
          is_ctl  <= sin;
          bit_cnt <= 3'd7;
        end
        S_PAYLOAD: begin
          pay     <= {pay[6:0], sin};
          bit_cnt <= bit_cnt - 3'd1;
        end
        S_STOP: begin
          if (!sin) begin
            frame_err <= 1'b1;
            data_cnt  <= 3'd0;
          end else if (!is_ctl) begin
            if (data_cnt == 3'd4) begin
              frame_err <= 1'b1;
              data_cnt  <= 3'd0;
            end else begin
              c_sr     <= {c_sr[23:0], pay};
              data_cnt <= data_cnt + 3'd1;
            end
          end else if (!pay[7]) begin
            data_cnt <= 3'd0;
            if (data_cnt == 3'd4) begin
              rsp_valid     <= 1'b1;
              rsp_c         <= c_sr;
              rsp_flags     <= pay[6:3];
              rsp_crc_ok    <= (pay[2:0] == crc3({c_sr, 1'b0, pay[6:3]}));
              rsp_err       <= 1'b0;
              rsp_err_flags <= 6'h0;
              rsp_par_ok    <= 1'b0;
              rsp_raw       <= {raw_sr, sin};
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            data_cnt <= 3'd0;
            if (data_cnt == 3'd0) begin
              rsp_valid     <= 1'b1;
              rsp_c         <= 32'h0;
              rsp_flags     <= 4'h0;
              rsp_crc_ok    <= 1'b0;
              rsp_err       <= 1'b1;
              rsp_err_flags <= pay[6:1];
              rsp_par_ok    <= ~^pay;
              rsp_raw       <= 55'h0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_RSP_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  assign timeout_hit = (state == S_IDLE) && sin && (data_cnt != 3'd0) &&
                       (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (state == S_IDLE && sin && data_cnt != 3'd0 && !timeout_hit)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// tb/tb_alu_rsp_deserializer.sv - randomized self-checking bench against a frame-level reference model
module tb_alu_rsp_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        rsp_valid;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic        rsp_crc_ok;
  logic        rsp_err;
  logic [5:0]  rsp_err_flags;
  logic        rsp_par_ok;
  logic [54:0] rsp_raw;
  logic        frame_err;
  logic        timeout;

  alu_rsp_deserializer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .sin(sin),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .rsp_crc_ok(rsp_crc_ok), .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags),
    .rsp_par_ok(rsp_par_ok), .rsp_raw(rsp_raw), .frame_err(frame_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 1 = response, 2 = frame error
    logic [31:0] c;
    logic [3:0]  flags;
    logic        crc_ok;
    logic        err;
    logic [5:0]  ef;
    logic        par_ok;
    logic [54:0] raw;
    int          cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        mon_ev;
  logic [7:0] mdata[$];
  bit         rbits[$];
  int         cyc = 0;
  int         to_cnt = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      mon_ev = '{kind: 1, c: rsp_c, flags: rsp_flags, crc_ok: rsp_crc_ok, err: rsp_err,
                 ef: rsp_err_flags, par_ok: rsp_par_ok, raw: rsp_raw, cyc: cyc};
      obs_q.push_back(mon_ev);
    end
    if (frame_err === 1'b1) begin
      mon_ev = '{kind: 2, c: 0, flags: 0, crc_ok: 0, err: 0, ef: 0, par_ok: 0, raw: 0, cyc: cyc};
      obs_q.push_back(mon_ev);
    end
    if (timeout === 1'b1) to_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC as the remainder of polynomial long division of message*x^3 by x^3+x+1.
  function automatic logic [2:0] crc_ref(input logic [31:0] c, input logic [3:0] f);
    logic [63:0] m;
    m = {27'b0, c, 1'b0, f};
    m = m << 3;
    for (int i = 39; i >= 3; i--)
      if (m[i]) m = m ^ (64'hB << (i - 3));
    return m[2:0];
  endfunction

  task automatic model_clear();
    mdata.delete();
    rbits.delete();
  endtask

  task automatic model_frame(input bit is_ctl, input logic [7:0] b, input bit stop);
    ev_t e;
    e = '{kind: 2, c: 0, flags: 0, crc_ok: 0, err: 0, ef: 0, par_ok: 0, raw: 0, cyc: 0};
    rbits.push_back(1'b0);
    rbits.push_back(is_ctl);
    for (int i = 7; i >= 0; i--) rbits.push_back(b[i]);
    rbits.push_back(stop);
    if (!stop) begin
      exp_q.push_back(e);
      model_clear();
    end else if (!is_ctl) begin
      if (mdata.size() == 4) begin
        exp_q.push_back(e);
        model_clear();
      end else begin
        mdata.push_back(b);
      end
    end else if (!b[7]) begin
      if (mdata.size() == 4) begin
        e.kind   = 1;
        e.c      = {mdata[0], mdata[1], mdata[2], mdata[3]};
        e.flags  = b[6:3];
        e.crc_ok = (b[2:0] == crc_ref(e.c, b[6:3]));
        for (int i = 0; i < 55; i++) e.raw[54 - i] = rbits[i];
      end
      exp_q.push_back(e);
      model_clear();
    end else begin
      if (mdata.size() == 0) begin
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        e.kind   = 1;
        e.err    = 1'b1;
        e.ef     = b[6:1];
        e.par_ok = (ones % 2 == 0);
      end
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit is_ctl, input logic [7:0] b, input bit stop);
    logic [10:0] bits;
    model_frame(is_ctl, b, stop);
    bits = {1'b0, is_ctl, b, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_resp(input logic [31:0] c, input logic [7:0] ctl);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, c[i*8 +: 8], 1'b1);
    send_frame(1'b1, ctl, 1'b1);
  endtask

  task automatic drain();
    ev_t o, e;
    idle(3);
    check("event_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("kind", o.kind, e.kind);
      if (e.kind == 1) begin
        check("rsp_c", o.c, e.c);
        check("rsp_flags", o.flags, e.flags);
        check("rsp_crc_ok", o.crc_ok, e.crc_ok);
        check("rsp_err", o.err, e.err);
        check("rsp_raw", o.raw, e.raw);
        if (e.err) begin
          check("rsp_err_flags", o.ef, e.ef);
          check("rsp_par_ok", o.par_ok, e.par_ok);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, rsp_valid, 0);
    check({tag, "_c"}, rsp_c, 0);
    check({tag, "_flags"}, {rsp_flags, rsp_crc_ok, rsp_err, rsp_par_ok}, 0);
    check({tag, "_err_flags"}, rsp_err_flags, 0);
    check({tag, "_raw"}, rsp_raw, 0);
    check({tag, "_ferr"}, {frame_err, timeout}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic [3:0]  f;
    logic [7:0]  ctl;
    int          kind, n, bad;

    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Directed 1/2: good and bad CRC on C=0, flags=0010
    send_resp(32'h0, 8'h16);
    drain();
    check("t1_crc_ok", rsp_crc_ok, 1);
    send_resp(32'h0, 8'h17);
    drain();
    check("t2_crc_ok", rsp_crc_ok, 0);

    // Directed 3: lone error CTL with good then bad parity
    send_frame(1'b1, 8'h93, 1'b1);
    drain();
    check("t3_err_flags", rsp_err_flags, 6'b001001);
    check("t3_par_ok", rsp_par_ok, 1);
    send_frame(1'b1, 8'h92, 1'b1);
    drain();
    check("t3_par_bad", rsp_par_ok, 0);

    // Directed 4: short response then a good one
    send_frame(1'b0, 8'hAB, 1'b1);
    send_frame(1'b0, 8'hCD, 1'b1);
    send_frame(1'b1, 8'h16, 1'b1);
    c = 32'h1234_5678;
    send_resp(c, {1'b0, 4'b1001, crc_ref(c, 4'b1001)});
    drain();

    // Directed 5: back-to-back responses
    send_resp(32'hDEAD_BEEF, {1'b0, 4'b0101, crc_ref(32'hDEAD_BEEF, 4'b0101)});
    send_resp(32'h8000_0001, {1'b0, 4'b1110, crc_ref(32'h8000_0001, 4'b1110)});
    idle(2);
    if (obs_q.size() >= 2) check("b2b_gap", obs_q[1].cyc - obs_q[0].cyc, 55);
    else check("b2b_count", obs_q.size(), 2);
    drain();

    // Directed 6: reset in the middle of the 3rd DATA frame
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    sin = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sin = 1'b1;
    model_clear();
    check_outputs_zero("midrst");
    send_resp(32'hCAFE_F00D, {1'b0, 4'b0011, crc_ref(32'hCAFE_F00D, 4'b0011)});
    drain();

`ifdef ALU_RSP_TIMEOUT_EN
    send_frame(1'b0, 8'h5A, 1'b1);
    idle(63);
    check("timeout_early", to_cnt, 0);
    idle(3);
    check("timeout_pulse", to_cnt, 1);
    model_clear();
    send_resp(32'h0BAD_F00D, {1'b0, 4'b0110, crc_ref(32'h0BAD_F00D, 4'b0110)});
    drain();
`endif

    // Random mix of good, corrupted and malformed traffic
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      c    = $urandom;
      f    = 4'($urandom_range(0, 15));
      ctl  = {1'b0, f, crc_ref(c, f)};
      if (kind <= 4) begin
        if (kind == 4) ctl[$urandom_range(0, 2)] ^= 1'b1;
        for (int i = 3; i >= 0; i--) begin
          send_frame(1'b0, c[i*8 +: 8], 1'b1);
          idle($urandom_range(0, 2));
        end
        send_frame(1'b1, ctl, 1'b1);
      end else if (kind == 5) begin
        ctl = {1'b1, 7'($urandom_range(0, 127))};
        send_frame(1'b1, ctl, 1'b1);
      end else if (kind == 6) begin
        bad = $urandom_range(0, 3);
        for (int i = 0; i <= bad; i++) send_frame(1'b0, 8'($urandom), i != bad);
      end else if (kind == 7) begin
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'($urandom), 1'b1);
      end else begin
        n = (kind == 8) ? $urandom_range(1, 3) : $urandom_range(1, 4);
        for (int i = 0; i < n; i++) send_frame(1'b0, 8'($urandom), 1'b1);
        if (kind == 8) send_frame(1'b1, ctl, 1'b1);
        else send_frame(1'b1, {1'b1, 7'($urandom_range(0, 127))}, 1'b1);
      end
      idle($urandom_range(0, 2));
      if (it % 10 == 9) drain();
    end
    drain();

`ifndef ALU_RSP_TIMEOUT_EN
    check("no_timeout", to_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
